axil_master_bridge: RTL and testbench
=====================================

// Module: axil_master_bridge
// PURPOSE
//  Core-side AXI4-Lite master: converts the processor's single-outstanding request/response bus into
//  AXI4-Lite AW/W/AR/R transactions toward sysio-class slaves. The codebase's AXI4-Lite profile has no
//  B channel: a write completes when both AW and W handshakes have occurred. One transaction in flight.
// PARAMETERS
//  AW           32   address width (matches `MemAddrBus)
//  DW           32   data width (matches `MemBus); wstrb width = DW/8
//  TIMEOUT_CYC  255  cycles before a stalled transaction is aborted (used only with AXIM_TIMEOUT_EN)
// PORTS
//  clk          in   1     system clock
//  rst_n        in   1     async active-low reset
//  req_valid    in   1     core request valid
//  req_ready    out  1     bridge can accept request
//  req_we       in   1     1=write, 0=read
//  req_addr     in   AW    byte address
//  req_wdata    in   DW    write data
//  req_sel      in   DW/8  byte strobes
//  rsp_valid    out  1     response valid (held until rsp_ready)
//  rsp_ready    in   1     core accepts response
//  rsp_rdata    out  DW    read data (0 for writes)
//  rsp_err      out  1     1 = transaction aborted by timeout
//  m_awaddr/m_awvalid out, m_awready in; m_wdata/m_wstrb/m_wvalid out, m_wready in
//  m_araddr/m_arvalid out, m_arready in; m_rdata/m_rvalid in, m_rready out
// BEHAVIOUR
//  Clock clk; reset rst_n asynchronous, active-low. Reset: state IDLE; all valid outputs, m_rready,
//  rsp_valid, rsp_err = 0; address/data/rsp_rdata registers = 0. Reset mid-transaction drops all
//  valids at once; no transaction is retried.
//  FSM: IDLE, WR, RD_A, RD_D, RESP. req_ready = (state==IDLE), combinational.
//  IDLE: on req_valid&req_ready (cycle N) latch addr/wdata/sel; -> WR (we=1) or RD_A (we=0).
//  WR: m_awvalid and m_wvalid both high from N+1. Each drops individually the cycle after its own
//   ready is sampled high (AW and W may complete in different cycles, either order). When both done
//   -> RESP with rsp_rdata=0, rsp_err=0. Against a slave with combinational readys: rsp_valid at N+2.
//  RD_A: m_arvalid high from N+1 until m_arready sampled high -> RD_D.
//  RD_D: m_rready=1; on m_rvalid capture m_rdata into rsp_rdata -> RESP. m_arvalid & m_rready never
//   both high. Against sysio-class slave: rsp_valid at N+3.
//  RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready; on rsp_ready -> IDLE (next request
//   accepted no earlier than the following cycle). Requests during non-IDLE states are ignored (req_ready=0).
//  AXI payload outputs stay stable while their valid is high; valid never drops before ready (except timeout).
// CONFIGURATION
//  AXIM_TIMEOUT_EN defined: cycle counter cleared on entering WR/RD_A, counts in WR/RD_A/RD_D; reaching
//   TIMEOUT_CYC drops all m_* valids and m_rready next cycle and enters RESP with rsp_err=1,
//   rsp_rdata=AXIM_ERR_DATA (32'hDEAD_BEEF). Counter held 0 in IDLE/RESP.
//  Not defined: no counter; rsp_err tied 0; bridge waits indefinitely for slave readys/rvalid.
// STRUCTURE
//  defines.v: state encodings AXIM_S_IDLE..AXIM_S_RESP, AXIM_ERR_DATA; widths from `MemAddrBus/`MemBus.
//  Single flat module; the timeout counter is the one natural sub-module, axim_wdog (instantiated only
//  under AXIM_TIMEOUT_EN), outputs a one-cycle expire pulse.
// TESTING
//  1 Write 0x0000_0104 data 0xA5A5_1234 sel 4'b1111, slave readys combinational -> one cycle
//    AW+W valid, rsp_valid at N+2, rsp_rdata=0, rsp_err=0.
//  2 Write with m_awready at N+1, m_wready delayed to N+4 -> awvalid drops at N+2, wvalid held
//    with stable wdata until N+4, rsp_valid at N+5.
//  3 Read 0x0000_0200, slave returns 0x0000_00FF one cycle after AR -> rsp_rdata=0x0000_00FF
//    at N+3; rsp_ready held low 3 cycles -> rsp_valid/rdata stable, req_ready=0 throughout.
//  4 Back-to-back: req_valid held high with write then read -> second accepted only after
//    rsp handshake; no overlapping AW/AR valid.
//  5 AXIM_TIMEOUT_EN, TIMEOUT_CYC=8, arready never asserted -> arvalid drops after 8 cycles,
//    rsp_err=1, rsp_rdata=32'hDEAD_BEEF; without macro arvalid stays high 100+ cycles.
//  6 rst_n low during RD_D -> m_rready, m_arvalid, rsp_valid 0 immediately; after release
//    req_ready=1 and a new read completes normally.

Source files
------------

// File: rtl/axil_master_bridge_pkg.sv
// axil_master_bridge_pkg: bridge FSM state encodings and abort read-data constant.
// Rev 1.0
`default_nettype none
package axil_master_bridge_pkg;

  typedef enum logic [2:0] {
    AXIM_S_IDLE = 3'd0,
    AXIM_S_WR   = 3'd1,
    AXIM_S_RD_A = 3'd2,
    AXIM_S_RD_D = 3'd3,
    AXIM_S_RESP = 3'd4
  } axim_state_t;

  localparam logic [31:0] AXIM_ERR_DATA = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/axil_master_bridge_wdog.sv
// axil_master_bridge_wdog: counts busy cycles, one-cycle expire pulse at LIMIT.
// Rev 1.0
`default_nettype none
module axil_master_bridge_wdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // cnt==k means run has been high for k cycles before this one
  assign expire = run && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axil_master_bridge.sv
// axil_master_bridge: single-outstanding core bus to AXI4-Lite (no B channel) master.
// Optional stall abort via AXIM_TIMEOUT_EN. Rev 1.0
`default_nettype none
module axil_master_bridge
  import axil_master_bridge_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_sel,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic [AW-1:0]   m_awaddr,
  output logic            m_awvalid,
  input  logic            m_awready,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wstrb,
  output logic            m_wvalid,
  input  logic            m_wready,
  output logic [AW-1:0]   m_araddr,
  output logic            m_arvalid,
  input  logic            m_arready,
  input  logic [DW-1:0]   m_rdata,
  input  logic            m_rvalid,
  output logic            m_rready
);

  axim_state_t     state, state_nxt;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] sel_q;
  logic [DW-1:0]   rdata_q;
  logic            aw_done, w_done;
  logic            aw_hs, w_hs;
  logic            expire;

  assign m_awaddr  = addr_q;
  assign m_araddr  = addr_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = sel_q;
  assign rsp_rdata = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= AXIM_S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    case (state)
      AXIM_S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_we ? AXIM_S_WR : AXIM_S_RD_A;
      end
      AXIM_S_WR: begin
        m_awvalid = !aw_done;
        m_wvalid  = !w_done;
        aw_hs     = m_awvalid && m_awready;
        w_hs      = m_wvalid && m_wready;
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = AXIM_S_RESP;
      end
      AXIM_S_RD_A: begin
        m_arvalid = 1'b1;
        if (m_arready) state_nxt = AXIM_S_RD_D;
      end
      AXIM_S_RD_D: begin
        m_rready = 1'b1;
        if (m_rvalid) state_nxt = AXIM_S_RESP;
      end
      AXIM_S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = AXIM_S_IDLE;
      end
      default: state_nxt = AXIM_S_IDLE;
    endcase
    // An abort wins over a same-cycle handshake so the error response is unambiguous
    if (expire) state_nxt = AXIM_S_RESP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (expire) begin
      rdata_q <= DW'(AXIM_ERR_DATA);
    end else begin
      case (state)
        AXIM_S_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            sel_q   <= req_sel;
            rdata_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        AXIM_S_WR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        AXIM_S_RD_D: begin
          if (m_rvalid) rdata_q <= m_rdata;
        end
        default: ;
      endcase
    end
  end

`ifdef AXIM_TIMEOUT_EN
  logic err_q;
  logic busy;

  assign busy    = (state == AXIM_S_WR) || (state == AXIM_S_RD_A) || (state == AXIM_S_RD_D);
  assign rsp_err = err_q;

  axil_master_bridge_wdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (busy),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   err_q <= 1'b0;
    else if (expire)                              err_q <= 1'b1;
    else if (state == AXIM_S_IDLE && req_valid)   err_q <= 1'b0;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYC;
  assign expire  = 1'b0;
  assign rsp_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axil_master_bridge.sv
// tb_axil_master_bridge: directed self-checking bench for axil_master_bridge.
// Rev 1.0
`default_nettype none
module tb_axil_master_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;

  int vectors = 0;
  int errors  = 0;

  axil_master_bridge #(.AW(32), .DW(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ck(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic bad;
    rst_n = 1'b0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_sel = 0;
    rsp_ready = 0; m_awready = 0; m_wready = 0; m_arready = 0; m_rvalid = 0; m_rdata = 0;
    tick(); tick();
    ck("rst_req_ready", req_ready, 1);
    ck("rst_valids", {m_awvalid, m_wvalid, m_arvalid, m_rready, rsp_valid, rsp_err}, 0);
    ck("rst_regs", {m_awaddr, rsp_rdata}, 0);
    rst_n = 1'b1;
    tick();

    // 1: write, combinational slave readys
    m_awready = 1; m_wready = 1;
    req_valid = 1; req_we = 1; req_addr = 32'h0000_0104; req_wdata = 32'hA5A5_1234; req_sel = 4'hF;
    ck("t1_req_ready_N", req_ready, 1);
    tick(); req_valid = 0; req_wdata = 32'h0;
    ck("t1_aw_w_valid_N1", {m_awvalid, m_wvalid, rsp_valid}, 3'b110);
    ck("t1_payload_N1", {m_awaddr, m_wdata, 28'h0, m_wstrb}, {32'h0000_0104, 32'hA5A5_1234, 32'hF});
    tick();
    ck("t1_rsp_N2", {m_awvalid, m_wvalid, rsp_valid, rsp_err, req_ready}, 5'b00100);
    ck("t1_rdata_N2", rsp_rdata, 0);
    rsp_ready = 1; tick(); rsp_ready = 0;
    ck("t1_back_idle", {req_ready, rsp_valid}, 2'b10);

    // 2: AW ready immediately, W ready only at N+4
    m_awready = 1; m_wready = 0;
    req_valid = 1; req_we = 1; req_addr = 32'h0000_0300; req_wdata = 32'h1122_3344; req_sel = 4'h3;
    tick(); req_valid = 0;
    ck("t2_N1", {m_awvalid, m_wvalid}, 2'b11);
    tick();
    ck("t2_N2", {m_awvalid, m_wvalid, rsp_valid}, 3'b010);
    ck("t2_wdata_N2", {m_wdata, m_wstrb}, {32'h1122_3344, 4'h3});
    tick();
    ck("t2_N3", {m_wvalid, m_wdata}, {1'b1, 32'h1122_3344});
    tick(); m_wready = 1;
    ck("t2_N4", {m_wvalid, rsp_valid}, 2'b10);
    tick();
    ck("t2_N5", {m_awvalid, m_wvalid, rsp_valid, rsp_err}, 4'b0010);
    rsp_ready = 1; tick(); rsp_ready = 0;

    // 3: read with one-cycle R latency, slow response consumer
    m_arready = 1;
    req_valid = 1; req_we = 0; req_addr = 32'h0000_0200;
    tick(); req_valid = 0;
    ck("t3_N1", {m_arvalid, m_rready, m_araddr}, {2'b10, 32'h0000_0200});
    tick(); m_rvalid = 1; m_rdata = 32'h0000_00FF;
    ck("t3_N2", {m_arvalid, m_rready}, 2'b01);
    tick(); m_rvalid = 0; m_rdata = 32'h0;
    ck("t3_N3", {rsp_valid, rsp_rdata, rsp_err}, {1'b1, 32'h0000_00FF, 1'b0});
    req_valid = 1; req_we = 1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid !== 1 || rsp_rdata !== 32'hFF || req_ready !== 0 || m_awvalid !== 0) bad = 1;
      tick();
    end
    ck("t3_hold_stable", bad, 0);
    req_valid = 0;
    rsp_ready = 1; tick(); rsp_ready = 0;

    // 4: back-to-back with req_valid held high
    m_awready = 1; m_wready = 1; m_arready = 1;
    req_valid = 1; req_we = 1; req_addr = 32'h0000_0010; req_wdata = 32'hCAFE_0001; req_sel = 4'hF;
    tick();
    req_we = 0; req_addr = 32'h0000_0020;
    ck("t4_N1", {req_ready, m_awvalid, m_arvalid}, 3'b010);
    tick();
    ck("t4_N2", {rsp_valid, req_ready, m_arvalid}, 3'b100);
    rsp_ready = 1; tick(); rsp_ready = 0;
    ck("t4_second_accept", {req_ready, m_arvalid, m_awvalid}, 3'b100);
    tick(); req_valid = 0;
    ck("t4_rd_N1", {m_arvalid, m_awvalid, m_wvalid, m_araddr}, {3'b100, 32'h0000_0020});
    tick(); m_rvalid = 1; m_rdata = 32'h0BAD_F00D;
    tick(); m_rvalid = 0;
    ck("t4_rd_rsp", {rsp_valid, rsp_rdata}, {1'b1, 32'h0BAD_F00D});
    rsp_ready = 1; tick(); rsp_ready = 0;

    // 5: AR never accepted
    m_arready = 0;
    req_valid = 1; req_we = 0; req_addr = 32'h0000_0400;
    tick(); req_valid = 0;
`ifdef AXIM_TIMEOUT_EN
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_arvalid !== 1) bad = 1;
      tick();
    end
    ck("t5_arvalid_8cyc", bad, 0);
    ck("t5_abort", {m_arvalid, m_rready, rsp_valid, rsp_err}, 4'b0011);
    ck("t5_err_data", rsp_rdata, 32'hDEAD_BEEF);
    rsp_ready = 1; tick(); rsp_ready = 0;
    ck("t5_idle", {req_ready, rsp_valid}, 2'b10);
`else
    bad = 0;
    for (int i = 0; i < 105; i++) begin
      if (m_arvalid !== 1 || m_araddr !== 32'h0000_0400 || rsp_valid !== 0) bad = 1;
      tick();
    end
    ck("t5_arvalid_held", bad, 0);
    ck("t5_no_err", rsp_err, 0);
    m_arready = 1; tick(); m_arready = 0;
    m_rvalid = 1; m_rdata = 32'h0000_0055; tick(); m_rvalid = 0;
    ck("t5_late_rsp", {rsp_valid, rsp_rdata}, {1'b1, 32'h0000_0055});
    rsp_ready = 1; tick(); rsp_ready = 0;
`endif

    // 6: asynchronous reset while waiting in RD_D
    m_arready = 1;
    req_valid = 1; req_we = 0; req_addr = 32'h0000_0500;
    tick(); req_valid = 0;
    tick();
    ck("t6_in_rd_d", {m_rready, m_arvalid}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    ck("t6_async_drop", {m_rready, m_arvalid, rsp_valid, m_awvalid, m_wvalid}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    ck("t6_req_ready", req_ready, 1);
    req_valid = 1; req_we = 0; req_addr = 32'h0000_0600;
    tick(); req_valid = 0;
    ck("t6_new_ar", {m_arvalid, m_araddr}, {1'b1, 32'h0000_0600});
    tick(); m_rvalid = 1; m_rdata = 32'h1234_5678;
    tick(); m_rvalid = 0;
    ck("t6_new_rsp", {rsp_valid, rsp_rdata, rsp_err}, {1'b1, 32'h1234_5678, 1'b0});
    rsp_ready = 1; tick(); rsp_ready = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
